// File: rtl/hs32_bus_arb_pkg.sv
// Shared definitions for the hs32 bus arbiter: FSM state encoding, grant identifiers,
// watchdog width and the default read data returned on a terminated transaction.
package hs32_bus_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_WB     = 2'd1,
        ARB_CPU    = 2'd2,
        ARB_WBDONE = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_CPU = 1'b0,
        GRANT_WB  = 1'b1
    } grant_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;
    localparam int          WDOG_W           = 8;

    // A Wishbone access only writes when at least one byte lane is selected.
    function automatic logic wb_is_write(input logic we, input logic [3:0] sel);
        return we & (|sel);
    endfunction

endpackage

// File: rtl/hs32_arb_wdog.sv
// Transaction watchdog: loadable saturating counter that flags the busy cycle in which
// the count reaches TIMEOUT-1.
module hs32_arb_wdog
    import hs32_bus_arb_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);

    localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT - 1);

    logic [WDOG_W-1:0] r_cnt;
    logic [WDOG_W-1:0] w_cnt_inc;

    // Saturating increment so a stuck enable never wraps back to zero.
    always_comb begin
        if (r_cnt == {WDOG_W{1'b1}}) begin
            w_cnt_inc = r_cnt;
        end else begin
            w_cnt_inc = r_cnt + WDOG_W'(1);
        end
    end

    // Counter register: load clears, enable counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_cnt_inc;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_expire = i_en & ~i_load & (w_cnt_inc == LIMIT);

endmodule

// File: rtl/hs32_bus_arb.sv
// hs32_bus_arb: sequential Wishbone / hs32 CPU arbiter in front of the MMIO/SRAM slave bus.
// One downstream transaction at a time; acks go only to the owner; hung slaves are timed out.
module hs32_bus_arb
    import hs32_bus_arb_pkg::*;
#(
    parameter int          TIMEOUT  = 64,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        cpu_stb,
    input  logic        cpu_rw,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_dout,
    output logic        cpu_ack,
    output logic [31:0] cpu_din,
    output logic        s_stb,
    output logic        s_rw,
    output logic [31:0] s_addr,
    output logic [31:0] s_dtw,
    input  logic        s_ack,
    input  logic [31:0] s_dtr,
    output logic        timeout,
    output logic        busy
);

    arb_state_t  r_state, w_state_n;
    grant_t      r_last_grant, w_last_grant_n;
    logic        r_cpu_pend, w_cpu_pend_n;
    logic        r_pend_rw, w_pend_rw_n;
    logic [31:0] r_pend_addr, w_pend_addr_n;
    logic [31:0] r_pend_dout, w_pend_dout_n;
    logic        r_s_stb, w_s_stb_n;
    logic        r_s_rw, w_s_rw_n;
    logic [31:0] r_s_addr, w_s_addr_n;
    logic [31:0] r_s_dtw, w_s_dtw_n;
    logic        r_wbs_ack, w_wbs_ack_n;
    logic [31:0] r_wbs_dat, w_wbs_dat_n;
    logic        r_cpu_ack, w_cpu_ack_n;
    logic [31:0] r_cpu_din, w_cpu_din_n;
    logic        r_timeout, w_timeout_n;
    logic        r_busy, w_busy_n;
    logic        w_wb_req, w_cpu_elig, w_wd_load, w_wd_expire;

    assign w_wb_req   = wbs_cyc_i & wbs_stb_i;
    assign w_cpu_elig = r_cpu_pend & ~hold;

    hs32_arb_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_wd_load),
        .i_en     (r_busy),
        .o_expire (w_wd_expire)
    );

    // Next-state, pending-slot capture, grant selection and ack routing.
    always_comb begin
        w_state_n      = r_state;
        w_last_grant_n = r_last_grant;
        w_cpu_pend_n   = r_cpu_pend;
        w_pend_rw_n    = r_pend_rw;
        w_pend_addr_n  = r_pend_addr;
        w_pend_dout_n  = r_pend_dout;
        w_s_stb_n      = 1'b0;
        w_s_rw_n       = r_s_rw;
        w_s_addr_n     = r_s_addr;
        w_s_dtw_n      = r_s_dtw;
        w_wbs_ack_n    = 1'b0;
        w_wbs_dat_n    = 32'h0000_0000;
        w_cpu_ack_n    = 1'b0;
        w_cpu_din_n    = 32'h0000_0000;
        w_timeout_n    = 1'b0;
        w_wd_load      = 1'b0;

        // A strobe while a request is already pending violates the CPU protocol and is dropped.
        if (cpu_stb && !r_cpu_pend) begin
            w_cpu_pend_n  = 1'b1;
            w_pend_rw_n   = cpu_rw;
            w_pend_addr_n = cpu_addr;
            w_pend_dout_n = cpu_dout;
        end else begin
            w_cpu_pend_n  = r_cpu_pend;
        end

        case (r_state)
            ARB_IDLE: begin
                if (w_wb_req && (!w_cpu_elig || (r_last_grant == GRANT_CPU))) begin
                    w_s_stb_n      = 1'b1;
                    w_s_rw_n       = wb_is_write(wbs_we_i, wbs_sel_i);
                    w_s_addr_n     = wbs_adr_i;
                    w_s_dtw_n      = wbs_dat_i;
                    w_wd_load      = 1'b1;
                    w_last_grant_n = GRANT_WB;
                    w_state_n      = ARB_WB;
                end else if (w_cpu_elig) begin
                    w_s_stb_n      = 1'b1;
                    w_s_rw_n       = r_pend_rw;
                    w_s_addr_n     = r_pend_addr;
                    w_s_dtw_n      = r_pend_dout;
                    w_wd_load      = 1'b1;
                    w_last_grant_n = GRANT_CPU;
                    w_state_n      = ARB_CPU;
                end else begin
                    w_state_n      = ARB_IDLE;
                end
            end
            ARB_WB: begin
                // A master that has abandoned its cycle gets no ack; s_ack beats the watchdog.
                if (s_ack || w_wd_expire) begin
                    w_wbs_ack_n = w_wb_req;
                    w_wbs_dat_n = !w_wb_req ? 32'h0000_0000 : (s_ack ? s_dtr : ERR_DATA);
                    w_timeout_n = ~s_ack;
                    w_state_n   = ARB_WBDONE;
                end else begin
                    w_state_n   = ARB_WB;
                end
            end
            ARB_CPU: begin
                if (s_ack || w_wd_expire) begin
                    w_cpu_ack_n  = 1'b1;
                    w_cpu_din_n  = s_ack ? s_dtr : ERR_DATA;
                    w_timeout_n  = ~s_ack;
                    w_cpu_pend_n = 1'b0;
                    w_state_n    = ARB_IDLE;
                end else begin
                    w_state_n    = ARB_CPU;
                end
            end
            ARB_WBDONE: begin
                w_state_n = ARB_IDLE;
            end
            default: begin
                w_state_n = ARB_IDLE;
            end
        endcase

        w_busy_n = (w_state_n == ARB_WB) || (w_state_n == ARB_CPU);
    end

    // State, pending CPU slot and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ARB_IDLE;
            r_last_grant <= GRANT_CPU;
            r_cpu_pend   <= 1'b0;
            r_pend_rw    <= 1'b0;
            r_pend_addr  <= 32'h0000_0000;
            r_pend_dout  <= 32'h0000_0000;
            r_s_stb      <= 1'b0;
            r_s_rw       <= 1'b0;
            r_s_addr     <= 32'h0000_0000;
            r_s_dtw      <= 32'h0000_0000;
            r_wbs_ack    <= 1'b0;
            r_wbs_dat    <= 32'h0000_0000;
            r_cpu_ack    <= 1'b0;
            r_cpu_din    <= 32'h0000_0000;
            r_timeout    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_last_grant <= w_last_grant_n;
            r_cpu_pend   <= w_cpu_pend_n;
            r_pend_rw    <= w_pend_rw_n;
            r_pend_addr  <= w_pend_addr_n;
            r_pend_dout  <= w_pend_dout_n;
            r_s_stb      <= w_s_stb_n;
            r_s_rw       <= w_s_rw_n;
            r_s_addr     <= w_s_addr_n;
            r_s_dtw      <= w_s_dtw_n;
            r_wbs_ack    <= w_wbs_ack_n;
            r_wbs_dat    <= w_wbs_dat_n;
            r_cpu_ack    <= w_cpu_ack_n;
            r_cpu_din    <= w_cpu_din_n;
            r_timeout    <= w_timeout_n;
            r_busy       <= w_busy_n;
        end
    end

    assign wbs_ack_o = r_wbs_ack;
    assign wbs_dat_o = r_wbs_dat;
    assign cpu_ack   = r_cpu_ack;
    assign cpu_din   = r_cpu_din;
    assign s_stb     = r_s_stb;
    assign s_rw      = r_s_rw;
    assign s_addr    = r_s_addr;
    assign s_dtw     = r_s_dtw;
    assign timeout   = r_timeout;
    assign busy      = r_busy;

endmodule
